// File: rtl/ula_ports.sv
// ula_ports: ULA I/O port block (CPU clock-enable divider, port FE, optional 7FFD paging).
// Defining ULA_PAGING_128K_EN adds the 7FFD paging register; otherwise the paging outputs are tied to 0.
`default_nettype none

module ula_ports #(
    parameter int CLK_DIV = 8,
    parameter int BANK_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              n_iorq,
    input  logic              n_wr,
    input  logic              n_rd,
    input  logic              n_m1,
    input  logic [4:0]        key_data,
    input  logic              ear_in,
    output logic              cpu_ce,
    output logic [2:0]        border,
    output logic              mic,
    output logic              beeper,
    output logic [BANK_W-1:0] bank,
    output logic              shadow_scr,
    output logic              rom_sel,
    output logic              locked,
    output logic [7:0]        rd_data,
    output logic              rd_valid
);

    localparam int                DIV_W   = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             wr_prev_q;
    logic [2:0]       border_q, border_d;
    logic             mic_q, mic_d;
    logic             beeper_q, beeper_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic wr_stb, rd_stb, wr_commit;

    // Both strobes exclude interrupt acknowledge (M1 low during IORQ).
    assign wr_stb    = ~n_iorq & ~n_wr & n_m1;
    assign rd_stb    = ~n_iorq & ~n_rd & n_m1;
    assign wr_commit = wr_stb & ~wr_prev_q;

    always_comb begin
        div_d      = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        border_d   = border_q;
        mic_d      = mic_q;
        beeper_d   = beeper_q;
        if (wr_commit && !cpu_addr[0]) begin
            border_d = cpu_dout[2:0];
            mic_d    = cpu_dout[3];
            beeper_d = cpu_dout[4];
        end
        rd_valid_d = rd_stb & ~cpu_addr[0];
        rd_data_d  = rd_valid_d ? {1'b1, ear_in, 1'b1, key_data} : 8'hFF;
    end

    // Edge history resets to "strobe high" so a strobe held through reset cannot commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            wr_prev_q  <= 1'b1;
            border_q   <= 3'd0;
            mic_q      <= 1'b0;
            beeper_q   <= 1'b0;
            rd_data_q  <= 8'hFF;
            rd_valid_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            wr_prev_q  <= wr_stb;
            border_q   <= border_d;
            mic_q      <= mic_d;
            beeper_q   <= beeper_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef ULA_PAGING_128K_EN
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              shadow_q, shadow_d;
    logic              rom_q, rom_d;
    logic              locked_q, locked_d;
    logic              w_unused_dout;

    assign w_unused_dout = ^cpu_dout[7:6];

    always_comb begin
        bank_d   = bank_q;
        shadow_d = shadow_q;
        rom_d    = rom_q;
        locked_d = locked_q;
        if (wr_commit && !locked_q && !cpu_addr[15] && !cpu_addr[1] && cpu_addr[0]) begin
            bank_d   = cpu_dout[BANK_W-1:0];
            shadow_d = cpu_dout[3];
            rom_d    = cpu_dout[4];
            locked_d = cpu_dout[5];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q   <= '0;
            shadow_q <= 1'b0;
            rom_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            shadow_q <= shadow_d;
            rom_q    <= rom_d;
            locked_q <= locked_d;
        end
    end

    assign bank       = bank_q;
    assign shadow_scr = shadow_q;
    assign rom_sel    = rom_q;
    assign locked     = locked_q;
`else
    logic w_unused_paging;

    assign w_unused_paging = ^{cpu_addr[15:1], cpu_dout[7:5]};

    assign bank       = '0;
    assign shadow_scr = 1'b0;
    assign rom_sel    = 1'b0;
    assign locked     = 1'b0;
`endif

    assign cpu_ce   = (div_q == DIV_MAX);
    assign border   = border_q;
    assign mic      = mic_q;
    assign beeper   = beeper_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ula_ports.sv
// Self-checking bench for ula_ports: transaction-level model plus per-cycle compare process.
`default_nettype none

module tb_ula_ports;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        n_iorq = 1'b1, n_wr = 1'b1, n_rd = 1'b1, n_m1 = 1'b1;
    logic [4:0]  key_data = 5'h1F;
    logic        ear_in = 1'b0;

    logic       ce_a, ce_b;
    logic [2:0] border_a, border_b;
    logic       mic_a, mic_b, beeper_a, beeper_b;
    logic [2:0] bank_a;
    logic [0:0] bank_b;
    logic       shadow_a, shadow_b, rom_a, rom_b, locked_a, locked_b;
    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b;

    ula_ports #(.CLK_DIV(8), .BANK_W(3)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_iorq(n_iorq), .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1),
        .key_data(key_data), .ear_in(ear_in), .cpu_ce(ce_a), .border(border_a),
        .mic(mic_a), .beeper(beeper_a), .bank(bank_a), .shadow_scr(shadow_a),
        .rom_sel(rom_a), .locked(locked_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    ula_ports #(.CLK_DIV(2), .BANK_W(1)) dut2 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_iorq(n_iorq), .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1),
        .key_data(key_data), .ear_in(ear_in), .cpu_ce(ce_b), .border(border_b),
        .mic(mic_b), .beeper(beeper_b), .bank(bank_b), .shadow_scr(shadow_b),
        .rom_sel(rom_b), .locked(locked_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected architectural state, updated per transaction by the stimulus tasks.
    logic [2:0] exp_border = 3'd0;
    logic       exp_mic = 1'b0, exp_beeper = 1'b0;
    logic [2:0] exp_bank = 3'd0;
    logic       exp_bank2 = 1'b0;
    logic       exp_shadow = 1'b0, exp_rom = 1'b0, exp_locked = 1'b0;

    logic [7:0] exp_rd = 8'hFF;
    logic       exp_rv = 1'b0;
    int         n_since_reset = 0;
    bit         started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        exp_border = 3'd0; exp_mic = 1'b0; exp_beeper = 1'b0;
        exp_bank = 3'd0; exp_bank2 = 1'b0;
        exp_shadow = 1'b0; exp_rom = 1'b0; exp_locked = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        if (!a[0]) begin
            exp_border = d[2:0]; exp_mic = d[3]; exp_beeper = d[4];
        end
`ifdef ULA_PAGING_128K_EN
        else if (!a[15] && !a[1] && !exp_locked) begin
            exp_bank = d[2:0]; exp_bank2 = d[0];
            exp_shadow = d[3]; exp_rom = d[4]; exp_locked = d[5];
        end
`endif
    endtask

    // Read result and clock-enable phase follow directly from the sampled bus each edge.
    always @(posedge clk) begin
        if (reset) begin
            started = 1'b1;
            n_since_reset = 0;
            exp_rd = 8'hFF;
            exp_rv = 1'b0;
        end else begin
            n_since_reset++;
            if (!n_iorq && !n_rd && n_m1 && !cpu_addr[0]) begin
                exp_rd = {1'b1, ear_in, 1'b1, key_data};
                exp_rv = 1'b1;
            end else begin
                exp_rd = 8'hFF;
                exp_rv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ce8",      32'(ce_a),       32'(n_since_reset % 8 == 7));
            check("ce2",      32'(ce_b),       32'(n_since_reset % 2 == 1));
            check("border",   32'(border_a),   32'(exp_border));
            check("border2",  32'(border_b),   32'(exp_border));
            check("mic",      32'(mic_a),      32'(exp_mic));
            check("beeper",   32'(beeper_a),   32'(exp_beeper));
            check("bank",     32'(bank_a),     32'(exp_bank));
            check("bank2",    32'(bank_b),     32'(exp_bank2));
            check("shadow",   32'(shadow_a),   32'(exp_shadow));
            check("rom_sel",  32'(rom_a),      32'(exp_rom));
            check("locked",   32'(locked_a),   32'(exp_locked));
            check("locked2",  32'(locked_b),   32'(exp_locked));
            check("rd_data",  32'(rd_data_a),  32'(exp_rd));
            check("rd_valid", 32'(rd_valid_a), 32'(exp_rv));
            check("rd_data2", 32'(rd_data_b),  32'(exp_rd));
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
    endtask

    // Strobe held for `hold` edges; data is flipped after the commit edge to expose re-commits.
    task automatic io_out(input logic [15:0] a, input logic [7:0] d, input int hold);
        @(posedge clk); #1;
        cpu_addr = a; cpu_dout = d; n_iorq = 1'b0; n_wr = 1'b0;
        @(posedge clk); #1;
        model_write(a, d);
        cpu_dout = ~d;
        repeat (hold - 1) @(posedge clk);
        #1 n_iorq = 1'b1; n_wr = 1'b1;
        @(posedge clk);
    endtask

    task automatic io_in(input logic [15:0] a);
        @(posedge clk); #1;
        cpu_addr = a; n_iorq = 1'b0; n_rd = 1'b0;
        @(posedge clk); #1;
        n_iorq = 1'b1; n_rd = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("first_ce8", 32'(ce_a), 32'(k == 7));
            check("first_ce2", 32'(ce_b), 32'(k % 2 == 1));
        end

        io_out(16'h00FE, 8'h15, 4);
        #1;
        check("fe15_border", 32'(border_a), 32'd5);
        check("fe15_mic",    32'(mic_a),    32'd0);
        check("fe15_beeper", 32'(beeper_a), 32'd1);
        io_out(16'h7FFC, 8'h0A, 2);

        key_data = 5'b11110; ear_in = 1'b0;
        io_in(16'h00FE);
        check("in_be_data",  32'(rd_data_a),  32'hBE);
        check("in_be_valid", 32'(rd_valid_a), 32'd1);
        @(posedge clk); #1;
        check("idle_data",  32'(rd_data_a),  32'hFF);
        check("idle_valid", 32'(rd_valid_a), 32'd0);
        io_in(16'h00FF);
        key_data = 5'b01010; ear_in = 1'b1;
        io_in(16'hFFFE);
        check("in_ea_data", 32'(rd_data_a), 32'hEA);

        io_out(16'h7FFD, 8'h3B, 2);
        check("7ffd_border_kept", 32'(border_a), 32'd2);
`ifdef ULA_PAGING_128K_EN
        check("3b_bank",   32'(bank_a),   32'd3);
        check("3b_shadow", 32'(shadow_a), 32'd1);
        check("3b_rom",    32'(rom_a),    32'd1);
        check("3b_locked", 32'(locked_a), 32'd1);
`else
        check("3b_bank_off",   32'(bank_a),   32'd0);
        check("3b_locked_off", 32'(locked_a), 32'd0);
`endif
        io_out(16'h7FFD, 8'h07, 1);
`ifdef ULA_PAGING_128K_EN
        check("locked_bank", 32'(bank_a), 32'd3);
`endif
        do_reset();
        #1;
        check("rst_bank",   32'(bank_a),   32'd0);
        check("rst_locked", 32'(locked_a), 32'd0);
        check("rst_border", 32'(border_a), 32'd0);

        io_out(16'h7FFD, 8'h07, 3);
`ifdef ULA_PAGING_128K_EN
        check("07_bank3", 32'(bank_a), 32'd7);
        check("07_bank1", 32'(bank_b), 32'd1);
`else
        check("07_bank_off", 32'(bank_a), 32'd0);
`endif
        io_out(16'hFFFD, 8'h02, 1);
        io_out(16'h7FFF, 8'h05, 1);
        io_out(16'h00FE, 8'h0F, 1);

        // Write and read both asserted in the reset cycle; write held past release.
        @(posedge clk); #1;
        reset = 1'b1; cpu_addr = 16'h00FE; cpu_dout = 8'h17;
        n_iorq = 1'b0; n_wr = 1'b0; n_rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; n_rd = 1'b1; model_reset();
        repeat (3) @(posedge clk);
        #1 n_iorq = 1'b1; n_wr = 1'b1;
        check("held_wr_border", 32'(border_a), 32'd0);
        check("held_wr_beeper", 32'(beeper_a), 32'd0);
        io_out(16'h00FE, 8'h13, 2);
        check("rerise_border", 32'(border_a), 32'd3);

        // Interrupt acknowledge with both data strobes low must touch nothing.
        @(posedge clk); #1;
        cpu_addr = 16'h00FE; cpu_dout = 8'h07;
        n_m1 = 1'b0; n_iorq = 1'b0; n_wr = 1'b0; n_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("intack_border", 32'(border_a),   32'd3);
        check("intack_valid",  32'(rd_valid_a), 32'd0);
        n_m1 = 1'b1; n_iorq = 1'b1; n_wr = 1'b1; n_rd = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
